// File: rtl/mips32r2_tlb_pkg.sv
// Shared MIPS32r2 TLB types: entry layout, page-size encodings and the VPN2 compare mask.
package mips32r2_tlb_pkg;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;

  typedef enum logic [1:0] {
    PS4K  = 2'd0,
    PS16K = 2'd1,
    PS64K = 2'd2
  } page_size_e;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    page_size_e        ps;
    logic [PFN_W-1:0]  pfn0;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c0;
    logic [2:0]        c1;
    logic              d0;
    logic              d1;
    logic              v0;
    logic              v1;
    logic              ri0;
    logic              ri1;
    logic              xi0;
    logic              xi1;
  } tlb_entry_t;

  // Larger pages ignore the low VPN2 bits; unknown encodings compare as 4K.
  function automatic logic [VPN2_W-1:0] vpn2_mask(page_size_e ps);
    case (ps)
      PS16K:   return VPN2_W'(19'h7fffc);
      PS64K:   return VPN2_W'(19'h7fff0);
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/mips32r2_tlb_group_match.sv
// Compares one group of TLB entries against a probe and picks the lowest matching slot.
module mips32r2_tlb_group_match
  import mips32r2_tlb_pkg::*;
#(
  parameter int unsigned GROUP_SIZE = 4,
  parameter int unsigned OW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
  input  tlb_entry_t              entries [GROUP_SIZE],
  input  logic [GROUP_SIZE-1:0]   valid,
  input  logic [VPN2_W-1:0]       vpn2,
  input  logic [ASID_W-1:0]       asid,
  output logic                    hit_c,
  output logic [OW-1:0]           offset_c,
  output tlb_entry_t              entry_c
);

  logic [VPN2_W-1:0] mask;

  // Walk downwards so the lowest matching slot is the one left standing.
  always_comb begin
    hit_c    = 1'b0;
    offset_c = '0;
    entry_c  = '0;
    mask     = '1;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      mask = vpn2_mask(entries[i].ps);
      if (valid[i] && ((entries[i].vpn2 & mask) == (vpn2 & mask)) &&
          (entries[i].g || (entries[i].asid == asid))) begin
        hit_c    = 1'b1;
        offset_c = OW'(i);
        entry_c  = entries[i];
      end
    end
  end

endmodule

// File: rtl/mips32r2_tlb_prober.sv
// Main TLB array with a grouped, multi-cycle probe scanner, TLBR/TLBW access and Random register.
// Optional: define TLB_RANDOM_EN for a live Random register; otherwise it is tied to ENTRIES-1.
module mips32r2_tlb_prober
  import mips32r2_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES    = 64,
  parameter int unsigned GROUP_SIZE = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [VPN2_W-1:0]           p_ivpn2,
  input  logic [ASID_W-1:0]           p_iasid,
  output logic                        p_ready,
  output logic [$clog2(ENTRIES)-1:0]  p_index,
  output tlb_entry_t                  p_resp,
  input  logic                        w_valid,
  input  logic [$clog2(ENTRIES)-1:0]  w_index,
  input  tlb_entry_t                  w_entry,
  input  logic [$clog2(ENTRIES)-1:0]  r_index,
  output tlb_entry_t                  r_entry,
  input  logic [$clog2(ENTRIES)-1:0]  c_wired,
  input  logic                        c_wired_we,
  output logic [$clog2(ENTRIES)-1:0]  r_random
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned NG = ENTRIES / GROUP_SIZE;
  localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned OW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

  tlb_entry_t                 entry_q [ENTRIES];
  logic [ENTRIES-1:0]         valid_q;
  logic [GW-1:0]              grp_q;
  logic [VPN2_W+ASID_W-1:0]   query_q;

  tlb_entry_t                 grp_ent_c [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]      grp_val_c;
  logic [IW-1:0]              base_c;
  logic                       hit_c;
  logic [OW-1:0]              offset_c;
  tlb_entry_t                 hit_entry_c;
  logic                       restart_c;

  assign restart_c = ({p_ivpn2, p_iasid} != query_q) || w_valid;
  assign base_c    = IW'(grp_q) * IW'(GROUP_SIZE);
  assign r_entry   = entry_q[r_index];

  always_comb begin
    for (int i = 0; i < GROUP_SIZE; i++) begin
      grp_ent_c[i] = entry_q[base_c + IW'(i)];
      grp_val_c[i] = valid_q[base_c + IW'(i)];
    end
  end

  mips32r2_tlb_group_match #(
    .GROUP_SIZE (GROUP_SIZE),
    .OW         (OW)
  ) u_group_match (
    .entries  (grp_ent_c),
    .valid    (grp_val_c),
    .vpn2     (p_ivpn2),
    .asid     (p_iasid),
    .hit_c    (hit_c),
    .offset_c (offset_c),
    .entry_c  (hit_entry_c)
  );

  // Scan pointer, hit response and array writes; a restart suppresses the current hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
      valid_q <= '0;
      grp_q   <= '0;
      query_q <= '0;
      p_ready <= 1'b0;
      p_index <= '0;
      p_resp  <= '0;
    end else begin
      query_q <= {p_ivpn2, p_iasid};
      if (restart_c)                  grp_q <= '0;
      else if (grp_q == GW'(NG - 1))  grp_q <= '0;
      else                            grp_q <= grp_q + GW'(1);
      p_ready <= hit_c && !restart_c;
      if (hit_c && !restart_c) begin
        p_index <= base_c + IW'(offset_c);
        p_resp  <= hit_entry_c;
      end
      if (w_valid) begin
        entry_q[w_index] <= w_entry;
        valid_q[w_index] <= 1'b1;
      end
    end
  end

`ifdef TLB_RANDOM_EN
  // Random counts down through the non-wired entries and reloads at the wired boundary.
  always_ff @(posedge clock) begin
    if (reset || c_wired_we || (c_wired >= IW'(ENTRIES - 1)) || (r_random <= c_wired))
      r_random <= IW'(ENTRIES - 1);
    else
      r_random <= r_random - IW'(1);
  end
`else
  logic unused_wired;
  assign unused_wired = ^{c_wired, c_wired_we};
  assign r_random     = IW'(ENTRIES - 1);
`endif

endmodule

// File: tb/tb_mips32r2_tlb_prober.sv
// Directed bench for mips32r2_tlb_prober: probe latency, masking, restarts, reset and Random.
module tb_mips32r2_tlb_prober;
  import mips32r2_tlb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic [18:0]       p_ivpn2;
  logic [7:0]        p_iasid;
  logic              p_ready;
  logic [5:0]        p_index;
  tlb_entry_t        p_resp;
  logic              w_valid;
  logic [5:0]        w_index;
  tlb_entry_t        w_entry;
  logic [5:0]        r_index;
  tlb_entry_t        r_entry;
  logic [5:0]        c_wired;
  logic              c_wired_we;
  logic [5:0]        r_random;

  int total = 0;
  int bad   = 0;

  mips32r2_tlb_prober #(.ENTRIES(64), .GROUP_SIZE(4)) dut (
    .clock(clock), .reset(reset),
    .p_ivpn2(p_ivpn2), .p_iasid(p_iasid), .p_ready(p_ready),
    .p_index(p_index), .p_resp(p_resp),
    .w_valid(w_valid), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .c_wired(c_wired), .c_wired_we(c_wired_we), .r_random(r_random)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                    input logic g, input page_size_e ps, input logic [19:0] pfn0);
    tlb_entry_t e;
    e      = '0;
    e.vpn2 = vpn2;
    e.asid = asid;
    e.g    = g;
    e.ps   = ps;
    e.pfn0 = pfn0;
    e.pfn1 = ~pfn0;
    e.c0   = 3'd3;
    e.v0   = 1'b1;
    e.d1   = 1'b1;
    return e;
  endfunction

  task automatic wr(input logic [5:0] idx, input tlb_entry_t e);
    w_valid = 1'b1;
    w_index = idx;
    w_entry = e;
    @(negedge clock);
    w_valid = 1'b0;
  endtask

  // Returns the number of negedges until p_ready, or 0 on timeout.
  task automatic wait_hit(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (p_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic no_hit(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (p_ready) seen = 1'b1;
    end
  endtask

  tlb_entry_t e37, e37g, e4, e4b, e6, e20, e50;
  int         n;
  logic       seen;
  logic [5:0] rnd_exp [6];

  initial begin
    e37  = mk(19'h12345, 8'd5, 1'b0, PS4K,  20'hABCDE);
    e37g = mk(19'h12345, 8'd5, 1'b1, PS4K,  20'hABCDE);
    e4   = mk(19'h10000, 8'd1, 1'b0, PS64K, 20'h44444);
    e4b  = mk(19'h10000, 8'd1, 1'b0, PS64K, 20'h4BBBB);
    e6   = mk(19'h1000F, 8'd1, 1'b0, PS4K,  20'h66666);
    e20  = mk(19'h20000, 8'd1, 1'b0, PS16K, 20'h20202);
    e50  = mk(19'h07777, 8'd2, 1'b0, PS4K,  20'h50505);
`ifdef TLB_RANDOM_EN
    rnd_exp = '{6'd63, 6'd62, 6'd61, 6'd60, 6'd63, 6'd62};
`else
    rnd_exp = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
`endif

    reset = 1'b1; p_ivpn2 = '0; p_iasid = '0; w_valid = 1'b0; w_index = '0;
    w_entry = '0; r_index = 6'd37; c_wired = 6'd60; c_wired_we = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_p_ready", 128'(p_ready), 128'(0));
    check("rst_p_index", 128'(p_index), 128'(0));
    check("rst_p_resp",  128'(p_resp),  128'(0));
    check("rst_r_entry", 128'(r_entry), 128'(0));

    // Random sequence out of reset with Wired=60, then a Wired write reloads it.
    reset = 1'b0;
    check("random_0", 128'(r_random), 128'(rnd_exp[0]));
    for (int k = 1; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("random_%0d", k), 128'(r_random), 128'(rnd_exp[k]));
    end
    c_wired_we = 1'b1;
    @(negedge clock);
    c_wired_we = 1'b0;
    check("random_wired_we", 128'(r_random), 128'(63));

    // Basic hit in group 9.
    wr(6'd37, e37);
    #1 check("tlbr_37", 128'(r_entry), 128'(e37));
    p_ivpn2 = 19'h12345; p_iasid = 8'd5;
    wait_hit(17, n);
    check("hit37_latency", 128'(n), 128'(11));
    check("hit37_index", 128'(p_index), 128'(37));
    check("hit37_resp", 128'(p_resp), 128'(e37));
    @(negedge clock);
    check("hit37_one_pulse", 128'(p_ready), 128'(0));

    // ASID mismatch misses; global bit then makes it hit.
    p_iasid = 8'd6;
    no_hit(40, seen);
    check("asid_miss", 128'(seen), 128'(0));
    wr(6'd37, e37g);
    wait_hit(17, n);
    check("global_latency", 128'(n), 128'(10));
    check("global_index", 128'(p_index), 128'(37));
    check("global_resp", 128'(p_resp), 128'(e37g));

    // Page-mask matching and lowest-index priority.
    wr(6'd4, e4);
    wr(6'd6, e6);
    wr(6'd20, e20);
    p_ivpn2 = 19'h1000F; p_iasid = 8'd1;
    wait_hit(17, n);
    check("ps64k_latency", 128'(n), 128'(3));
    check("ps64k_index", 128'(p_index), 128'(4));
    check("ps64k_resp", 128'(p_resp), 128'(e4));
    p_ivpn2 = 19'h20003;
    wait_hit(17, n);
    check("ps16k_latency", 128'(n), 128'(7));
    check("ps16k_index", 128'(p_index), 128'(20));
    p_ivpn2 = 19'h20004;
    no_hit(20, seen);
    check("ps16k_miss", 128'(seen), 128'(0));

    // Query change just before the hitting compare: no stale pulse.
    p_ivpn2 = 19'h1000F;
    repeat (2) @(negedge clock);
    p_ivpn2 = 19'h55555;
    @(negedge clock);
    check("stale_suppressed", 128'(p_ready), 128'(0));
    no_hit(20, seen);
    check("stale_no_late_hit", 128'(seen), 128'(0));

    // Query change while grp=7 restarts the scan at group 0.
    p_ivpn2 = 19'h55554;
    repeat (8) @(negedge clock);
    p_ivpn2 = 19'h1000F;
    wait_hit(17, n);
    check("midscan_restart", 128'(n), 128'(3));
    check("midscan_index", 128'(p_index), 128'(4));

    // A write in the hit cycle suppresses the pulse.
    p_ivpn2 = 19'h55555;
    @(negedge clock);
    p_ivpn2 = 19'h1000F;
    repeat (2) @(negedge clock);
    wr(6'd50, e50);
    check("write_suppress", 128'(p_ready), 128'(0));
    wait_hit(17, n);
    check("after_write_latency", 128'(n), 128'(2));

    // Rewriting the reported entry leaves p_resp alone; new data shows on the next hit.
    wr(6'd4, e4b);
    check("resp_held", 128'(p_resp), 128'(e4));
    check("resp_held_ready", 128'(p_ready), 128'(0));
    wait_hit(17, n);
    check("rewrite_latency", 128'(n), 128'(2));
    check("rewrite_resp", 128'(p_resp), 128'(e4b));

    // Reset one cycle before a hit aborts it and wipes the array.
    p_ivpn2 = 19'h12345; p_iasid = 8'd5;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_abort", 128'(p_ready), 128'(0));
    check("reset_p_index", 128'(p_index), 128'(0));
    reset = 1'b0;
    r_index = 6'd37;
    #1 check("reset_r_entry37", 128'(r_entry), 128'(0));
    no_hit(40, seen);
    check("reset_no_hit", 128'(seen), 128'(0));
    p_ivpn2 = '0; p_iasid = '0;
    no_hit(20, seen);
    check("reset_zero_query", 128'(seen), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
